vending_machine_ctrl: RTL and testbench

- Single-clock vending controller for an 8-slot machine.
- Accepts either a card payment (external credit balance) or coins (nickel, dime, quarter, dollar) for a selected slot.
- Checks price and stock, pulses a dispense strobe, decrements its internal inventory, and reports change as a total plus a greedy quarter/dime/nickel coin breakdown.
- Sits between the front-panel/coin-acceptor logic and the dispense/coin-return mechanics.

---
 rtl/vending_machine_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_vending_machine_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_ctrl.sv
// Vending controller for 8 slots: card or coin payment, stock tracking, greedy change.
// Define DOLLAR_COIN_EN to accept the dollar coin input as 100 cents.
module vending_machine_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  index,
  input  logic        payment_method,
  input  logic [8:0]  credit_balance,
  input  logic        nickel,
  input  logic        dime,
  input  logic        quarter,
  input  logic        dollar,
  input  logic [63:0] cost,
  input  logic        cancel,
  input  logic [23:0] current_inventory,
  output logic        dispensed,
  output logic [8:0]  change,
  output logic [4:0]  quart,
  output logic [4:0]  dim,
  output logic [4:0]  nick
);

  localparam int unsigned NUM_ITEMS = 8;
  localparam int unsigned PRICE_W   = 8;
  localparam int unsigned INV_W     = 3;
  localparam int unsigned CREDIT_W  = 9;
  localparam int unsigned COIN_W    = 5;
  localparam int unsigned SEL_W     = 4;
  localparam int unsigned SLOT_W    = 3;
  localparam int unsigned SUM_W     = CREDIT_W + 1;

  localparam logic [1:0] ST_INIT    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_VEND    = 2'd2;
  localparam logic [1:0] ST_CHANGE  = 2'd3;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [CREDIT_W-1:0] credit;
  logic [SEL_W-1:0]    sel_reg;
  logic [INV_W-1:0]    inv [NUM_ITEMS];
  logic                card_lock;
  logic                card_txn;
  logic                nickel_q;
  logic                dime_q;
  logic                quarter_q;
  logic                dollar_rise;

  logic                do_cancel;
  logic                do_select;
  logic                coin_en;

  // Greedy quarter/dime/nickel split of an amount; sub-nickel remainder is dropped.
  function automatic logic [3*COIN_W-1:0] coin_split(input logic [CREDIT_W-1:0] amt);
    logic [CREDIT_W-1:0] rem_q;
    logic [CREDIT_W-1:0] rem_d;
    rem_q = amt % CREDIT_W'(25);
    rem_d = rem_q % CREDIT_W'(10);
    return {COIN_W'(amt / CREDIT_W'(25)),
            COIN_W'(rem_q / CREDIT_W'(10)),
            COIN_W'(rem_d / CREDIT_W'(5))};
  endfunction

`ifdef DOLLAR_COIN_EN
  logic dollar_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dollar_q <= 1'b0;
    else      dollar_q <= dollar;
  end

  assign dollar_rise = dollar & ~dollar_q;
`else
  logic unused_dollar;

  assign unused_dollar = dollar;
  assign dollar_rise   = 1'b0;
`endif

  // Coin insertions count once per rising edge; simultaneous coins are summed.
  logic                nickel_rise;
  logic                dime_rise;
  logic                quarter_rise;
  logic [SUM_W-1:0]    coin_sum;
  logic [SUM_W-1:0]    credit_sum;
  logic                coin_fits;

  assign nickel_rise  = nickel  & ~nickel_q;
  assign dime_rise    = dime    & ~dime_q;
  assign quarter_rise = quarter & ~quarter_q;

  always_comb begin
    coin_sum = '0;
    if (nickel_rise)  coin_sum = coin_sum + SUM_W'(5);
    if (dime_rise)    coin_sum = coin_sum + SUM_W'(10);
    if (quarter_rise) coin_sum = coin_sum + SUM_W'(25);
    if (dollar_rise)  coin_sum = coin_sum + SUM_W'(100);
  end

  assign credit_sum = {1'b0, credit} + coin_sum;
  assign coin_fits  = ~credit_sum[CREDIT_W];

  // Selected-slot qualification.
  logic [SLOT_W-1:0]   slot;
  logic                slot_valid;
  logic [PRICE_W-1:0]  price;
  logic                stock_ok;
  logic                afford;
  logic                vend_ok;
  logic                sel_change;

  assign slot       = sel_reg[SLOT_W-1:0];
  assign slot_valid = ~sel_reg[SEL_W-1];
  assign price      = cost[{slot, 3'b000} +: PRICE_W];
  assign stock_ok   = (inv[slot] != '0);
  assign sel_change = (index != sel_reg);

  always_comb begin
    afford = 1'b0;
    if (payment_method) afford = !card_lock && (credit_balance >= CREDIT_W'(price));
    else                afford = (credit >= CREDIT_W'(price));
  end

  assign vend_ok = slot_valid && stock_ok && afford;

  // Next-state and per-cycle control decode.
  always_comb begin
    state_nxt = state;
    do_cancel = 1'b0;
    do_select = 1'b0;
    coin_en   = 1'b0;
    case (state)
      ST_INIT:    state_nxt = ST_COLLECT;
      ST_COLLECT: begin
        coin_en = !payment_method && !cancel;
        if (cancel)          do_cancel = 1'b1;
        else if (sel_change) do_select = 1'b1;
        else if (vend_ok)    state_nxt = ST_VEND;
      end
      ST_VEND:    state_nxt = ST_CHANGE;
      ST_CHANGE:  state_nxt = ST_COLLECT;
      default:    state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_INIT;
    else      state <= state_nxt;
  end

  // Datapath: credit, selection, inventory and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit    <= '0;
      sel_reg   <= '0;
      card_lock <= 1'b0;
      card_txn  <= 1'b0;
      nickel_q  <= 1'b0;
      dime_q    <= 1'b0;
      quarter_q <= 1'b0;
      dispensed <= 1'b0;
      change    <= '0;
      quart     <= '0;
      dim       <= '0;
      nick      <= '0;
      for (int unsigned k = 0; k < NUM_ITEMS; k++) inv[k] <= '0;
    end else begin
      nickel_q  <= nickel;
      dime_q    <= dime;
      quarter_q <= quarter;
      dispensed <= 1'b0;

      if (coin_en && coin_fits) credit <= credit_sum[CREDIT_W-1:0];

      case (state)
        ST_INIT: begin
          for (int unsigned k = 0; k < NUM_ITEMS; k++)
            inv[k] <= current_inventory[INV_W*k +: INV_W];
          sel_reg   <= index;
          card_lock <= 1'b0;
        end
        ST_COLLECT: begin
          if (do_cancel) begin
            if (payment_method) begin
              card_lock <= 1'b0;
            end else begin
              change              <= credit;
              {quart, dim, nick}  <= coin_split(credit);
              credit              <= '0;
            end
          end else if (do_select) begin
            sel_reg   <= index;
            card_lock <= 1'b0;
            change    <= '0;
            quart     <= '0;
            dim       <= '0;
            nick      <= '0;
          end
        end
        ST_VEND: begin
          dispensed <= 1'b1;
          inv[slot] <= inv[slot] - INV_W'(1);
          card_txn  <= payment_method;
          if (payment_method) begin
            change    <= credit_balance - CREDIT_W'(price);
            card_lock <= 1'b1;
          end else begin
            change <= credit - CREDIT_W'(price);
            credit <= '0;
          end
        end
        ST_CHANGE: begin
          if (card_txn) {quart, dim, nick} <= '0;
          else          {quart, dim, nick} <= coin_split(change);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vending_machine_ctrl.sv
// Directed self-checking bench for vending_machine_ctrl (default and DOLLAR_COIN_EN builds).
module tb_vending_machine_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  index;
  logic        payment_method;
  logic [8:0]  credit_balance;
  logic        nickel;
  logic        dime;
  logic        quarter;
  logic        dollar;
  logic [63:0] cost;
  logic        cancel;
  logic [23:0] current_inventory;
  logic        dispensed;
  logic [8:0]  change;
  logic [4:0]  quart;
  logic [4:0]  dim;
  logic [4:0]  nick;

  int n_checks;
  int n_fail;
  int disp_cnt;

  vending_machine_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .index             (index),
    .payment_method    (payment_method),
    .credit_balance    (credit_balance),
    .nickel            (nickel),
    .dime              (dime),
    .quarter           (quarter),
    .dollar            (dollar),
    .cost              (cost),
    .cancel            (cancel),
    .current_inventory (current_inventory),
    .dispensed         (dispensed),
    .change            (change),
    .quart             (quart),
    .dim               (dim),
    .nick              (nick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dispensed === 1'b1) disp_cnt <= disp_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One insertion held for a single clock, followed by enough idle cycles for a vend to finish.
  task automatic insert(input logic n, input logic d, input logic q, input logic dl);
    nickel = n; dime = d; quarter = q; dollar = dl;
    tick(1);
    nickel = 1'b0; dime = 1'b0; quarter = 1'b0; dollar = 1'b0;
    tick(5);
  endtask

  task automatic pulse_cancel();
    cancel = 1'b1;
    tick(1);
    cancel = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    disp_cnt = 0;
    rst = 1'b0;
    index = 4'd2;
    payment_method = 1'b1;
    credit_balance = 9'd200;
    nickel = 1'b0; dime = 1'b0; quarter = 1'b0; dollar = 1'b0;
    cancel = 1'b0;
    // Slot 0 costs 65 cents, every other slot 100.
    cost = {{7{8'd100}}, 8'd65};
    for (int k = 0; k < 8; k++)
      current_inventory[3*k +: 3] = (k == 5) ? 3'd1 : ((k == 6) ? 3'd0 : 3'd4);

    tick(3);
    check("reset_dispensed", 32'(dispensed), 0);
    check("reset_change", 32'(change), 0);
    check("reset_coins", 32'({quart, dim, nick}), 0);

    // Card vend on slot 2, then the single-vend lock.
    rst = 1'b1;
    tick(6);
    check("card1_count", disp_cnt, 1);
    check("card1_change", 32'(change), 100);
    check("card1_coins", 32'({quart, dim, nick}), 0);
    check("card1_stock", 32'(dut.inv[2]), 3);
    tick(10);
    check("card1_no_repeat", disp_cnt, 1);

    index = 4'd1;
    tick(6);
    check("card2_count", disp_cnt, 2);
    check("card2_change", 32'(change), 100);
    check("card2_stock", 32'(dut.inv[1]), 3);

`ifdef DOLLAR_COIN_EN
    payment_method = 1'b0;
    index = 4'd2;
    tick(2);
    check("coin_sel_clear", 32'(change), 0);
    insert(1'b1, 1'b0, 1'b0, 1'b1);
    check("coin1_count", disp_cnt, 3);
    check("coin1_change", 32'(change), 5);
    check("coin1_coins", 32'({quart, dim, nick}), 32'({5'd0, 5'd0, 5'd1}));
    index = 4'd9;
    tick(2);
    repeat (3) insert(1'b1, 1'b0, 1'b0, 1'b1);
    check("coin_invalid_hold", disp_cnt, 3);
    index = 4'd2;
    tick(6);
    check("coin2_count", disp_cnt, 4);
    check("coin2_change", 32'(change), 215);
    check("coin2_coins", 32'({quart, dim, nick}), 32'({5'd8, 5'd1, 5'd1}));
    check("coin2_stock", 32'(dut.inv[2]), 1);
`else
    payment_method = 1'b0;
    index = 4'd0;
    tick(2);
    check("coin_sel_clear", 32'(change), 0);
    repeat (3) insert(1'b0, 1'b0, 1'b1, 1'b0);
    check("coin1_count", disp_cnt, 3);
    check("coin1_change", 32'(change), 10);
    check("coin1_coins", 32'({quart, dim, nick}), 32'({5'd0, 5'd1, 5'd0}));
    index = 4'd9;
    tick(2);
    repeat (4) insert(1'b0, 1'b0, 1'b1, 1'b0);
    insert(1'b0, 1'b0, 1'b0, 1'b1);
    check("coin_invalid_hold", disp_cnt, 3);
    index = 4'd0;
    tick(6);
    check("coin2_count", disp_cnt, 4);
    check("coin2_change", 32'(change), 35);
    check("coin2_coins", 32'({quart, dim, nick}), 32'({5'd1, 5'd1, 5'd0}));
    check("coin2_stock", 32'(dut.inv[0]), 2);
`endif

    // Cancel refund below the price.
    index = 4'd2;
    tick(2);
    repeat (3) insert(1'b0, 1'b0, 1'b1, 1'b0);
    check("under_price_hold", disp_cnt, 4);
    pulse_cancel();
    check("cancel_change", 32'(change), 75);
    check("cancel_coins", 32'({quart, dim, nick}), 32'({5'd3, 5'd0, 5'd0}));
    tick(2);
    pulse_cancel();
    check("cancel_credit_zero", 32'(change), 0);

    // Cancel beats a vend that qualifies in the same cycle.
    index = 4'd9;
    tick(2);
    repeat (4) insert(1'b0, 1'b0, 1'b1, 1'b0);
    index = 4'd2;
    tick(1);
    pulse_cancel();
    tick(4);
    check("cancel_prio_count", disp_cnt, 4);
    check("cancel_prio_change", 32'(change), 100);
    check("cancel_prio_coins", 32'({quart, dim, nick}), 32'({5'd4, 5'd0, 5'd0}));

    // Empty slot holds credit.
    index = 4'd6;
    tick(2);
    repeat (8) insert(1'b0, 1'b0, 1'b1, 1'b0);
    check("empty_slot_count", disp_cnt, 4);
    pulse_cancel();
    check("empty_refund", 32'(change), 200);
    check("empty_refund_coins", 32'({quart, dim, nick}), 32'({5'd8, 5'd0, 5'd0}));

    // Credit ceiling: the quarter past 500 is dropped, the dime after it fits.
    repeat (21) insert(1'b0, 1'b0, 1'b1, 1'b0);
    insert(1'b0, 1'b1, 1'b0, 1'b0);
    pulse_cancel();
    check("overflow_refund", 32'(change), 510);
    check("overflow_coins", 32'({quart, dim, nick}), 32'({5'd20, 5'd1, 5'd0}));

    // Card mode: cancel re-arms the lock, invalid slot never vends.
    payment_method = 1'b1;
    index = 4'd3;
    tick(6);
    check("card3_count", disp_cnt, 5);
    tick(4);
    check("card3_locked", disp_cnt, 5);
    pulse_cancel();
    tick(5);
    check("card3_rearm_count", disp_cnt, 6);
    check("card3_stock", 32'(dut.inv[3]), 2);
    index = 4'd12;
    tick(6);
    check("card_invalid", disp_cnt, 6);

    // Mid-collection reset.
    payment_method = 1'b0;
    index = 4'd6;
    tick(2);
    repeat (2) insert(1'b0, 1'b0, 1'b1, 1'b0);
    pulse_cancel();
    check("pre_reset_change", 32'(change), 50);
    repeat (2) insert(1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    check("async_reset_change", 32'(change), 0);
    check("async_reset_coins", 32'({quart, dim, nick}), 0);
    tick(2);
    rst = 1'b1;
    tick(3);
    check("reload_stock2", 32'(dut.inv[2]), 4);
    check("reload_stock3", 32'(dut.inv[3]), 4);
    repeat (2) insert(1'b0, 1'b0, 1'b1, 1'b0);
    pulse_cancel();
    check("credit_lost", 32'(change), 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
